// File: rtl/multirate_v2_mul_pipe.sv
// ----------------------------------------------------------------------------
// multirate_v2_mul_pipe
//
// Pipelined multiply-accumulate with a valid/ready handshake on each side.
// Every accepted sample forms din0 x din1. The product, together with its
// first/last flags, moves through NUM_STAGE registers into an accumulator.
// A product tagged "last" closes the accumulation. The accumulator is then
// rounded (half toward +inf), shifted right by SHIFT, clamped to DOUT_W bits
// and registered as the result.
//
// A single clock enable (ce) moves the whole pipeline. ce is high whenever
// the output register is empty or is being drained, so a result that is not
// taken downstream stalls every stage.
//
// Parameters
//   DIN0_W      din0 width (always signed)
//   DIN1_W      din1 width
//   DIN1_SIGNED 0: din1 zero-extended, 1: din1 sign-extended
//   NUM_STAGE   product pipeline depth, 1..4
//   ACC_W       accumulator width, >= DIN0_W+DIN1_W
//   SHIFT       arithmetic right shift applied at the output, 0..ACC_W-1
//   DOUT_W      result width, <= ACC_W
//
// Ports
//   ap_clk      clock, rising edge
//   ap_rst_n    asynchronous active-low reset
//   in_valid    input sample valid
//   in_ready    input accepted when in_valid && in_ready (equals ce)
//   din0        signed operand
//   din1        operand, signedness set by DIN1_SIGNED
//   in_first    sample starts a new accumulation
//   in_last     sample ends the accumulation and produces a result
//   out_valid   result valid
//   out_ready   downstream accepts the result
//   dout        signed, rounded, clamped result
//   out_sat     dout was clamped
// ----------------------------------------------------------------------------
module multirate_v2_mul_pipe #(
   parameter int DIN0_W      = 16,
   parameter int DIN1_W      = 6,
   parameter int DIN1_SIGNED = 0,
   parameter int NUM_STAGE   = 2,
   parameter int ACC_W       = 32,
   parameter int SHIFT       = 0,
   parameter int DOUT_W      = 22
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DIN0_W-1:0] din0,
   input  logic        [DIN1_W-1:0] din1,
   input  logic                     in_first,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DOUT_W-1:0] dout,
   output logic                     out_sat
);

   localparam int PROD_W = DIN0_W + DIN1_W;

   // Rounding constant: half an output LSB, or nothing when no shift is applied.
   localparam int              RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [ACC_W:0]  RND    = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;

   // Clamp limits in the widened (ACC_W+1) rounding domain.
   localparam logic signed [ACC_W:0] MAX_V =
      {{(ACC_W-DOUT_W+2){1'b0}}, {(DOUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

   // -------------------------------------------------------------------------
   // Output / accumulator state
   // -------------------------------------------------------------------------
   logic                     out_valid_q, out_valid_d;
   logic signed [DOUT_W-1:0] dout_q, dout_d;
   logic                     out_sat_q, out_sat_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     pend_first_q, pend_first_d;

   logic ce;

   // The whole pipeline moves whenever the output register can take a value.
   assign ce       = !out_valid_q || out_ready;
   assign in_ready = ce;

   // -------------------------------------------------------------------------
   // Product formation
   // -------------------------------------------------------------------------
   // One guard bit lets an unsigned din1 enter a signed multiply unchanged.
   logic signed [DIN1_W:0]   din1_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;

   assign din1_ext = (DIN1_SIGNED != 0) ? $signed({din1[DIN1_W-1], din1})
                                        : $signed({1'b0, din1});

   // The exact product always fits in DIN0_W+DIN1_W signed bits.
   assign prod     = PROD_W'(din0) * PROD_W'(din1_ext);
   assign prod_ext = ACC_W'(prod);

   // -------------------------------------------------------------------------
   // Product pipeline
   // -------------------------------------------------------------------------
   logic [NUM_STAGE-1:0]    stg_vld_q;
   logic [NUM_STAGE-1:0]    stg_first_q;
   logic [NUM_STAGE-1:0]    stg_last_q;
   logic signed [ACC_W-1:0] stg_prod_q [NUM_STAGE];

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         stg_vld_q <= '0;
      end else if (ce) begin
         stg_vld_q[0] <= in_valid;
         for (int i = 1; i < NUM_STAGE; i++) begin
            stg_vld_q[i] <= stg_vld_q[i-1];
         end
      end
   end

   // NOTE: the payload registers carry no reset; a stage's contents are only
   // ever consumed when its valid bit (which is reset) is set.
   always_ff @(posedge ap_clk) begin
      if (ce) begin
         stg_prod_q[0]  <= prod_ext;
         stg_first_q[0] <= in_first;
         stg_last_q[0]  <= in_last;
         for (int i = 1; i < NUM_STAGE; i++) begin
            stg_prod_q[i]  <= stg_prod_q[i-1];
            stg_first_q[i] <= stg_first_q[i-1];
            stg_last_q[i]  <= stg_last_q[i-1];
         end
      end
   end

   logic                    ex_vld;
   logic                    ex_first;
   logic                    ex_last;
   logic signed [ACC_W-1:0] ex_prod;

   assign ex_vld   = stg_vld_q[NUM_STAGE-1];
   assign ex_first = stg_first_q[NUM_STAGE-1];
   assign ex_last  = stg_last_q[NUM_STAGE-1];
   assign ex_prod  = stg_prod_q[NUM_STAGE-1];

   // -------------------------------------------------------------------------
   // Accumulate, round, shift, clamp
   // -------------------------------------------------------------------------
   logic                    eff_first;
   logic signed [ACC_W-1:0] acc_new;
   logic signed [ACC_W:0]   rnd_sum;
   logic signed [ACC_W:0]   rnd_shr;
   logic signed [DOUT_W-1:0] res_val;
   logic                    res_sat;

   // After reset or after a closed accumulation, the next product always
   // restarts the sum, whatever its own first flag says.
   assign eff_first = ex_first || pend_first_q;
   assign acc_new   = eff_first ? ex_prod : acc_q + ex_prod;

   // Rounding is done one bit wider so adding the half-LSB cannot wrap.
   assign rnd_sum = $signed({acc_new[ACC_W-1], acc_new}) + $signed(RND);
   assign rnd_shr = rnd_sum >>> SHIFT;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      res_val = rnd_shr[DOUT_W-1:0];
      res_sat = 1'b0;
      if (rnd_shr > MAX_V) begin
         res_val = MAX_V[DOUT_W-1:0];
         res_sat = 1'b1;
      end else if (rnd_shr < MIN_V) begin
         res_val = MIN_V[DOUT_W-1:0];
         res_sat = 1'b1;
      end
   end

   // Next-state for accumulator and output register. Bubbles leave the
   // accumulator untouched; an accepted result drops out_valid unless a new
   // one is loaded in the same cycle.
   always_comb begin
      acc_d        = acc_q;
      pend_first_d = pend_first_q;
      out_valid_d  = out_valid_q;
      dout_d       = dout_q;
      out_sat_d    = out_sat_q;
      if (ce) begin
         out_valid_d = 1'b0;
         if (ex_vld) begin
            acc_d        = acc_new;
            pend_first_d = ex_last;
            if (ex_last) begin
               out_valid_d = 1'b1;
               dout_d      = res_val;
               out_sat_d   = res_sat;
            end
         end
      end
   end

   // NOTE: state registers take their next value with non-blocking
   // assignments so every register samples pre-edge values.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc_q        <= '0;
         pend_first_q <= 1'b1;
         out_valid_q  <= 1'b0;
         dout_q       <= '0;
         out_sat_q    <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         pend_first_q <= pend_first_d;
         out_valid_q  <= out_valid_d;
         dout_q       <= dout_d;
         out_sat_q    <= out_sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_multirate_v2_mul_pipe.sv
// ----------------------------------------------------------------------------
// tb_multirate_v2_mul_pipe
//
// Three instances share one stimulus stream:
//   u_def : default parameters
//   u_sh2 : SHIFT = 2
//   u_sgn : DIN1_SIGNED = 1
// A reference model computes every expected result from plain integer
// arithmetic when a sample is accepted. A monitor then compares each
// delivered result in order. Directed steps also check fixed known values,
// latency, stalling and reset.
// ----------------------------------------------------------------------------
module tb_multirate_v2_mul_pipe;

   localparam int DW = 22;

   logic               ap_clk = 1'b0;
   logic               ap_rst_n;
   logic               in_valid;
   logic signed [15:0] din0;
   logic        [5:0]  din1;
   logic               in_first;
   logic               in_last;
   logic               out_ready;

   logic               in_ready_a, in_ready_b, in_ready_c;
   logic               out_valid_a, out_valid_b, out_valid_c;
   logic signed [DW-1:0] dout_a, dout_b, dout_c;
   logic               sat_a, sat_b, sat_c;

   always #5 ap_clk = ~ap_clk;

   multirate_v2_mul_pipe u_def (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready), .dout(dout_a), .out_sat(sat_a));

   multirate_v2_mul_pipe #(.SHIFT(2)) u_sh2 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_b), .out_ready(out_ready), .dout(dout_b), .out_sat(sat_b));

   multirate_v2_mul_pipe #(.DIN1_SIGNED(1)) u_sgn (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
      .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_c), .out_ready(out_ready), .dout(dout_c), .out_sat(sat_c));

   // ------------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt  = 0;
   int n_push  = 0;
   int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   typedef struct {
      longint d0, d1, d2;
      bit     s0, s1, s2;
   } exp_t;

   exp_t   exp_q[$];
   longint acc_u, acc_s;
   bit     pend;

   function automatic void model_reset();
      n_push -= exp_q.size();
      exp_q.delete();
      acc_u = 0;
      acc_s = 0;
      pend  = 1'b1;
   endfunction

   function automatic void rnd_clamp(input longint a, input int sh,
                                     output longint r, output bit sat);
      longint lim;
      lim = longint'(1) <<< (DW - 1);
      r   = (a + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0))) >>> sh;
      sat = 1'b0;
      if (r > lim - 1) begin
         r = lim - 1; sat = 1'b1;
      end else if (r < -lim) begin
         r = -lim; sat = 1'b1;
      end
   endfunction

   function automatic void model_accept(input logic signed [15:0] a, input logic [5:0] b,
                                        input bit f, input bit l);
      longint pu, ps;
      bit     first;
      exp_t   e;
      pu    = longint'(a) * longint'(b);
      ps    = longint'(a) * longint'($signed(b));
      first = f || pend;
      acc_u = first ? pu : acc_u + pu;
      acc_s = first ? ps : acc_s + ps;
      acc_u = longint'(int'(acc_u));   // wrap modulo 2^32
      acc_s = longint'(int'(acc_s));
      pend  = l;
      if (l) begin
         rnd_clamp(acc_u, 0, e.d0, e.s0);
         rnd_clamp(acc_u, 2, e.d1, e.s1);
         rnd_clamp(acc_s, 0, e.d2, e.s2);
         exp_q.push_back(e);
         n_push++;
      end
   endfunction

   // ------------------------------------------------------------------------
   // out_ready driver and result monitor
   // ------------------------------------------------------------------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge ap_clk);
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge ap_clk);
         #2;
         if (ap_rst_n && out_valid_a && out_ready) begin
            hs_cnt++;
            check("ov_sh2_agree", out_valid_b, 1);
            check("ov_sgn_agree", out_valid_c, 1);
            if (exp_q.size() == 0) begin
               check("extra_result", out_valid_a, 0);
            end else begin
               e = exp_q.pop_front();
               check("dout_def", dout_a, e.d0);
               check("sat_def",  sat_a,  longint'(e.s0));
               check("dout_sh2", dout_b, e.d1);
               check("sat_sh2",  sat_b,  longint'(e.s1));
               check("dout_sgn", dout_c, e.d2);
               check("sat_sgn",  sat_c,  longint'(e.s2));
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic send(input logic signed [15:0] a, input logic [5:0] b,
                       input bit f, input bit l);
      bit done;
      done = 1'b0;
      @(negedge ap_clk);
      #1;
      in_valid = 1'b1; din0 = a; din1 = b; in_first = f; in_last = l;
      for (int k = 0; k < 200 && !done; k++) begin
         if (in_ready_a) begin
            model_accept(a, b, f, l);
            @(posedge ap_clk);
            done = 1'b1;
         end else begin
            @(negedge ap_clk);
            #1;
         end
      end
      if (!done) check("send_accept", in_ready_a, 1);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge ap_clk);
         #1;
         in_valid = 1'b0;
         in_first = 1'($urandom);
         in_last  = 1'($urandom);
      end
   endtask

   task automatic wait_out();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge ap_clk);
         #1;
         seen = out_valid_a;
      end
      if (!seen) check("out_valid_timeout", out_valid_a, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge ap_clk);
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      logic signed [DW-1:0] hold;
      int hs0;

      ap_rst_n = 1'b0;
      in_valid = 1'b0; din0 = '0; din1 = '0; in_first = 1'b0; in_last = 1'b0;
      model_reset();
      repeat (2) @(negedge ap_clk);
      #1;
      check("rst_out_valid", out_valid_a, 0);
      check("rst_dout",      dout_a, 0);
      check("rst_sat",       sat_a, 0);
      check("rst_in_ready",  in_ready_a, 1);
      ap_rst_n = 1'b1;

      // One-tap sample: exact latency and fixed values for all three configs.
      send(-3, 63, 1, 1);
      @(posedge ap_clk); #1;
      check("lat_not_yet", out_valid_a, 0);
      @(posedge ap_clk); #1;
      check("lat_valid",  out_valid_a, 1);
      check("onetap_def", dout_a, -189);
      check("onetap_sat", sat_a, 0);
      check("onetap_sh2", dout_b, -47);
      check("onetap_sgn", dout_c, 3);
      idle(3);

      // Four-tap accumulation.
      send(100, 2, 1, 0);
      send(200, 3, 0, 0);
      send(-50, 4, 0, 0);
      send(7,  63, 0, 1);
      wait_out();
      check("tap4_dout", dout_a, 1041);
      check("tap4_sat",  sat_a, 0);

      // Positive saturation.
      send(32767, 63, 1, 0);
      send(32767, 63, 0, 1);
      wait_out();
      check("possat_dout", dout_a, 2097151);
      check("possat_sat",  sat_a, 1);

      // Negative saturation.
      send(-32768, 63, 1, 0);
      send(-32768, 63, 0, 1);
      wait_out();
      check("negsat_dout", dout_a, -2097152);
      check("negsat_sat",  sat_a, 1);

      // After a last, a sample without in_first still starts afresh.
      send(10, 10, 0, 1);
      wait_out();
      check("implicit_first", dout_a, 100);
      idle(2);

      // Stall: result held, input blocked, then exactly one handshake.
      ready_mode = 0;
      @(negedge ap_clk);
      send(-3, 63, 1, 1);
      wait_out();
      hold = dout_a;
      check("stall_dout_first", dout_a, -189);
      for (int k = 0; k < 5; k++) begin
         @(negedge ap_clk); #1;
         check("stall_in_ready",  in_ready_a, 0);
         check("stall_out_valid", out_valid_a, 1);
         check("stall_dout",      dout_a, hold);
      end
      hs0 = hs_cnt;
      ready_mode = 1;
      @(negedge ap_clk); #1;
      @(negedge ap_clk); #1;
      check("release_ov_low", out_valid_a, 0);
      check("release_one_hs", hs_cnt, hs0 + 1);
      idle(5);
      check("release_no_dup", hs_cnt, hs0 + 1);

      // Randomized traffic with random backpressure.
      ready_mode = 2;
      for (int n = 0; n < 300; n++) begin
         idle($urandom_range(0, 2));
         send(16'($urandom), 6'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
      send(16'($urandom), 6'($urandom), 1'b0, 1'b1);
      ready_mode = 1;
      drain();

      // Reset in the middle of a four-tap accumulation.
      send(5, 5, 1, 1);
      wait_out();
      check("pre_reset_dout", dout_a, 25);
      send(100, 2, 1, 0);
      send(200, 3, 0, 0);
      @(negedge ap_clk); #1;
      ap_rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_out_valid", out_valid_a, 0);
      check("midrst_dout",      dout_a, 0);
      check("midrst_sat",       sat_a, 0);
      @(negedge ap_clk); #1;
      ap_rst_n = 1'b1;
      send(5, 5, 0, 1);
      wait_out();
      check("post_reset_dout", dout_a, 25);
      check("post_reset_sh2",  dout_b, 6);
      drain();
      idle(10);
      check("total_results", hs_cnt, n_push);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
